// File: rtl/mux_pkg.sv
// Shared constants for the mux_if primitive: select encoding and default data width.
package mux_pkg;

  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;

  localparam int MUX_W_DEFAULT = 1;

endpackage : mux_pkg

// File: rtl/dff_sr.sv
// WIDTH-bit D flip-flop with synchronous active-high clear to zero.
module dff_sr #(
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs before any of them update at the same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_out = q_q;

endmodule : dff_sr

// File: rtl/mux_if.sv
// 2:1 multiplexer decoded with an if/else; y_out is combinational and
// y_q_out is the same value registered one clock later.
module mux_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sel_in,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] y_q_out
);

  // NOTE: y_out is assigned on both branches, so no latch is inferred.
  // An unknown select falls through to the else branch and picks i0.
  always_comb begin
    if (sel_in == SEL_I1) begin
      y_out = i1;
    end else begin
      y_out = i0;
    end
  end

  dff_sr #(
    .WIDTH (WIDTH)
  ) u_y_reg (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (y_out),
    .q_out  (y_q_out)
  );

endmodule : mux_if

// File: tb/tb_mux_if.sv
// Directed self-checking bench for mux_if: a 1-bit and an 8-bit instance
// sharing clock and reset.
module tb_mux_if;

  logic       clk_in;
  logic       rst_in;

  logic       sel_1, i0_1, i1_1, y_1, yq_1;
  logic       sel_8;
  logic [7:0] i0_8, i1_8, y_8, yq_8;

  int n_cmp = 0;
  int n_mis = 0;

  mux_if #(.WIDTH(1)) dut_w1 (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .sel_in  (sel_1),
    .i0      (i0_1),
    .i1      (i1_1),
    .y_out   (y_1),
    .y_q_out (yq_1)
  );

  mux_if #(.WIDTH(8)) dut_w8 (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .sel_in  (sel_8),
    .i0      (i0_8),
    .i1      (i1_8),
    .y_out   (y_8),
    .y_q_out (yq_8)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%02h, want 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Combinational sweep vectors: {sel, i0, i1, expected y}
  logic [3:0] comb_vec [4] = '{4'b0_1_0_1, 4'b0_0_1_0, 4'b1_1_0_0, 4'b1_0_1_1};

  initial begin
    rst_in = 1'b1;
    sel_1  = 1'b0; i0_1 = 1'b0; i1_1 = 1'b0;
    sel_8  = 1'b0; i0_8 = 8'h00; i1_8 = 8'h00;

    // Reset state
    @(posedge clk_in); #1;
    check("reset_yq_w1", {7'd0, yq_1}, 8'h00);
    check("reset_yq_w8", yq_8, 8'h00);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Combinational sweep, checked 1 ns after each input change
    for (int k = 0; k < 4; k++) begin
      {sel_1, i0_1, i1_1} = comb_vec[k][3:1];
      #1;
      check($sformatf("comb_%0d", k), {7'd0, y_1}, {7'd0, comb_vec[k][0]});
      #4;
    end

    // Free-running toggles: i0 period 40, i1 period 20, sel period 20 (offset)
    for (int t = 0; t < 80; t += 5) begin
      i0_1  = ((t / 20) % 2) == 1;
      i1_1  = ((t / 10) % 2) == 1;
      sel_1 = (((t + 5) / 10) % 2) == 1;
      #1;
      check($sformatf("toggle_t%0d", t), {7'd0, y_1}, {7'd0, (sel_1 ? i1_1 : i0_1)});
      #4;
    end

    // Unknown select takes the else branch
    sel_1 = 1'bx; i0_1 = 1'b1; i1_1 = 1'b0;
    #1;
    check("sel_x_w1", {7'd0, y_1}, 8'h01);

    // Reset held for two edges with sel=0, i0=1
    @(negedge clk_in);
    rst_in = 1'b1; sel_1 = 1'b0; i0_1 = 1'b1; i1_1 = 1'b0;
    #1;
    check("rst_y_pre", {7'd0, y_1}, 8'h01);
    for (int e = 0; e < 2; e++) begin
      @(posedge clk_in); #1;
      check($sformatf("rst_yq_e%0d", e), {7'd0, yq_1}, 8'h00);
      check($sformatf("rst_y_e%0d", e), {7'd0, y_1}, 8'h01);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("rst_release_yq", {7'd0, yq_1}, 8'h01);

    // Latency: load A5 just after an edge on the 8-bit instance
    @(posedge clk_in); #1;
    sel_8 = 1'b1; i0_8 = 8'h3C; i1_8 = 8'hA5;
    #1;
    check("lat_y_now", y_8, 8'hA5);
    check("lat_yq_old", yq_8, 8'h00);
    @(posedge clk_in); #1;
    check("lat_yq_next", yq_8, 8'hA5);

    // Simultaneous select and data change
    @(negedge clk_in);
    sel_8 = 1'b0; i0_8 = 8'h5A; i1_8 = 8'hFF;
    #1;
    check("simul_y", y_8, 8'h5A);
    @(posedge clk_in); #1;
    check("simul_yq", yq_8, 8'h5A);

    // Mid-stream reset with y_q_out = A5
    @(negedge clk_in);
    sel_8 = 1'b1; i0_8 = 8'h3C; i1_8 = 8'hA5;
    @(posedge clk_in); #1;
    check("mid_pre_yq", yq_8, 8'hA5);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("mid_rst_yq", yq_8, 8'h00);
    check("mid_rst_y", y_8, 8'hA5);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("mid_release_yq", yq_8, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_mux_if
